// File: rtl/typedef_pkg.sv
// rtl/typedef_pkg.sv - shared state and requester encodings for the M_CU memory arbiter
package typedef_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CMD  = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_LD = 1'b0,
        ARB_ST = 1'b1
    } arb_req_t;

endpackage

// File: rtl/mcu_mem_arbiter_rr_arb2.sv
// rtl/mcu_mem_arbiter_rr_arb2.sv - two-requester round-robin grant, purely combinational
module rr_arb2
    import typedef_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_req_t   last_grant_i,
    output logic [1:0] gnt_o
);

    // Bit 0 is the load requester, bit 1 the store requester.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_grant_i == ARB_ST) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mcu_mem_arbiter.sv
// rtl/mcu_mem_arbiter.sv - arbitrates the external memory command port between load and store engines
module mcu_mem_arbiter
    import typedef_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_req_vld_i,
    output logic              ld_req_rdy_o,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [LEN_W-1:0]  ld_len_i,
    output logic              ld_done_o,
    input  logic              st_req_vld_i,
    output logic              st_req_rdy_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [LEN_W-1:0]  st_len_i,
    output logic              st_done_o,
    output logic              mem_cmd_vld_o,
    input  logic              mem_cmd_rdy_i,
    output logic [ADDR_W-1:0] mem_cmd_addr_o,
    output logic [LEN_W-1:0]  mem_cmd_len_o,
    output logic              mem_cmd_we_o,
    input  logic              mem_beat_i,
    output logic              err_o
);

    arb_state_t        state_q, state_d;
    arb_req_t          last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic              cmd_we_q, cmd_we_d;
    logic              cmd_vld_q, cmd_vld_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              ld_done_q, ld_done_d;
    logic              st_done_q, st_done_d;
    logic              err_q, err_d;
    logic [1:0]        gnt;
    logic              idle;

    rr_arb2 u_rr_arb2 (
        .req_i        ({st_req_vld_i, ld_req_vld_i}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign idle = (state_q == ARB_IDLE);

    // Gated by rstn so a requester holding vld during reset never sees rdy.
    assign ld_req_rdy_o = rstn & idle & gnt[0];
    assign st_req_rdy_o = rstn & idle & gnt[1];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_len_d    = cmd_len_q;
        cmd_we_d     = cmd_we_q;
        cnt_d        = cnt_q;
        ld_done_d    = 1'b0;
        st_done_d    = 1'b0;
        err_d        = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_beat_i) begin
                    err_d = 1'b1;
                end
                if (gnt[0]) begin
                    cmd_addr_d   = ld_addr_i;
                    cmd_len_d    = ld_len_i;
                    cmd_we_d     = 1'b0;
                    last_grant_d = ARB_LD;
                    state_d      = ARB_CMD;
                end else if (gnt[1]) begin
                    cmd_addr_d   = st_addr_i;
                    cmd_len_d    = st_len_i;
                    cmd_we_d     = 1'b1;
                    last_grant_d = ARB_ST;
                    state_d      = ARB_CMD;
                end
            end
            ARB_CMD: begin
                if (mem_beat_i) begin
                    err_d = 1'b1;
                end
                if (mem_cmd_rdy_i) begin
                    cnt_d   = cmd_len_q;
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (mem_beat_i) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else begin
                        state_d   = ARB_IDLE;
                        ld_done_d = ~cmd_we_q;
                        st_done_d = cmd_we_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        cmd_vld_d = (state_d == ARB_CMD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_ST;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            cmd_we_q     <= 1'b0;
            cmd_vld_q    <= 1'b0;
            cnt_q        <= '0;
            ld_done_q    <= 1'b0;
            st_done_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
            cmd_we_q     <= cmd_we_d;
            cmd_vld_q    <= cmd_vld_d;
            cnt_q        <= cnt_d;
            ld_done_q    <= ld_done_d;
            st_done_q    <= st_done_d;
            err_q        <= err_d;
        end
    end

    assign mem_cmd_vld_o  = cmd_vld_q;
    assign mem_cmd_addr_o = cmd_addr_q;
    assign mem_cmd_len_o  = cmd_len_q;
    assign mem_cmd_we_o   = cmd_we_q;
    assign ld_done_o      = ld_done_q;
    assign st_done_o      = st_done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_mcu_mem_arbiter.sv
// tb/tb_mcu_mem_arbiter.sv - directed self-checking bench for mcu_mem_arbiter
module tb_mcu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ld_req_vld_i = 1'b0;
    logic        ld_req_rdy_o;
    logic [31:0] ld_addr_i = '0;
    logic [7:0]  ld_len_i = '0;
    logic        ld_done_o;
    logic        st_req_vld_i = 1'b0;
    logic        st_req_rdy_o;
    logic [31:0] st_addr_i = '0;
    logic [7:0]  st_len_i = '0;
    logic        st_done_o;
    logic        mem_cmd_vld_o;
    logic        mem_cmd_rdy_i = 1'b0;
    logic [31:0] mem_cmd_addr_o;
    logic [7:0]  mem_cmd_len_o;
    logic        mem_cmd_we_o;
    logic        mem_beat_i = 1'b0;
    logic        err_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mcu_mem_arbiter #(.ADDR_W(32), .LEN_W(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ld_req_vld_i   (ld_req_vld_i),
        .ld_req_rdy_o   (ld_req_rdy_o),
        .ld_addr_i      (ld_addr_i),
        .ld_len_i       (ld_len_i),
        .ld_done_o      (ld_done_o),
        .st_req_vld_i   (st_req_vld_i),
        .st_req_rdy_o   (st_req_rdy_o),
        .st_addr_i      (st_addr_i),
        .st_len_i       (st_len_i),
        .st_done_o      (st_done_o),
        .mem_cmd_vld_o  (mem_cmd_vld_o),
        .mem_cmd_rdy_i  (mem_cmd_rdy_i),
        .mem_cmd_addr_o (mem_cmd_addr_o),
        .mem_cmd_len_o  (mem_cmd_len_o),
        .mem_cmd_we_o   (mem_cmd_we_o),
        .mem_beat_i     (mem_beat_i),
        .err_o          (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    // Packs every output so a whole-state comparison fits on one line.
    function automatic logic [47:0] outs();
        return {ld_req_rdy_o, st_req_rdy_o, ld_done_o, st_done_o, mem_cmd_vld_o,
                mem_cmd_we_o, err_o, 1'b0, mem_cmd_len_o, mem_cmd_addr_o};
    endfunction

    task automatic test_reset();
        ld_req_vld_i = 1'b1;
        st_req_vld_i = 1'b1;
        rstn = 1'b0;
        #3;
        total++;
        if (outs() !== 48'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), 48'h0);
        end
        ld_req_vld_i = 1'b0;
        st_req_vld_i = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_single_load();
        int ld_n;
        int st_n;
        ld_addr_i = 32'h1000;
        ld_len_i = 8'd3;
        ld_req_vld_i = 1'b1;
        mem_cmd_rdy_i = 1'b1;
        #1;
        total++;
        if ({ld_req_rdy_o, st_req_rdy_o} !== 2'b10) begin
            bad++;
            $display("FAIL single_rdy: got %b expected 10", {ld_req_rdy_o, st_req_rdy_o});
        end
        tick();
        ld_req_vld_i = 1'b0;
        total++;
        if ({mem_cmd_vld_o, mem_cmd_we_o, mem_cmd_addr_o, mem_cmd_len_o} !== {1'b1, 1'b0, 32'h1000, 8'd3}) begin
            bad++;
            $display("FAIL single_cmd: vld=%b we=%b addr=%h len=%0d expected vld=1 we=0 addr=1000 len=3",
                     mem_cmd_vld_o, mem_cmd_we_o, mem_cmd_addr_o, mem_cmd_len_o);
        end
        tick();
        total++;
        if (mem_cmd_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL single_vld_drop: got %b expected 0", mem_cmd_vld_o);
        end
        ld_n = 0;
        st_n = 0;
        mem_beat_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ld_n += int'(ld_done_o);
            st_n += int'(st_done_o);
        end
        total++;
        if (ld_n !== 0) begin
            bad++;
            $display("FAIL single_early_done: got %0d pulses expected 0", ld_n);
        end
        tick();
        mem_beat_i = 1'b0;
        total++;
        if ({ld_done_o, st_done_o} !== 2'b10) begin
            bad++;
            $display("FAIL single_done: got ld/st=%b expected 10", {ld_done_o, st_done_o});
        end
        st_n += int'(st_done_o);
        tick();
        total++;
        if ({ld_done_o, st_done_o, st_n[0]} !== 3'b000) begin
            bad++;
            $display("FAIL single_done_once: got ld=%b st=%b st_pulses=%0d expected 0 0 0", ld_done_o, st_done_o, st_n);
        end
    endtask

    task automatic test_alternation();
        logic exp_ld;
        apply_reset();
        ld_addr_i = 32'hA000;
        st_addr_i = 32'hB000;
        ld_len_i = 8'd0;
        st_len_i = 8'd0;
        ld_req_vld_i = 1'b1;
        st_req_vld_i = 1'b1;
        mem_cmd_rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ld = (k % 2 == 0);
            #1;
            total++;
            if ({ld_req_rdy_o, st_req_rdy_o} !== {exp_ld, ~exp_ld}) begin
                bad++;
                $display("FAIL alt_grant%0d: got ld/st rdy=%b expected %b", k, {ld_req_rdy_o, st_req_rdy_o}, {exp_ld, ~exp_ld});
            end
            tick();
            total++;
            if ({mem_cmd_vld_o, mem_cmd_we_o} !== {1'b1, ~exp_ld}) begin
                bad++;
                $display("FAIL alt_cmd%0d: got vld/we=%b expected %b", k, {mem_cmd_vld_o, mem_cmd_we_o}, {1'b1, ~exp_ld});
            end
            tick();
            mem_beat_i = 1'b1;
            tick();
            mem_beat_i = 1'b0;
            total++;
            if ({ld_done_o, st_done_o} !== {exp_ld, ~exp_ld}) begin
                bad++;
                $display("FAIL alt_done%0d: got ld/st=%b expected %b", k, {ld_done_o, st_done_o}, {exp_ld, ~exp_ld});
            end
        end
        ld_req_vld_i = 1'b0;
        st_req_vld_i = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int errs;
        apply_reset();
        ld_addr_i = 32'h2468;
        ld_len_i = 8'd1;
        st_addr_i = 32'h9000;
        st_len_i = 8'd2;
        mem_cmd_rdy_i = 1'b0;
        ld_req_vld_i = 1'b1;
        tick();
        ld_req_vld_i = 1'b0;
        st_req_vld_i = 1'b1;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ({mem_cmd_vld_o, mem_cmd_we_o, mem_cmd_addr_o, mem_cmd_len_o, st_req_rdy_o} !==
                {1'b1, 1'b0, 32'h2468, 8'd1, 1'b0}) begin
                errs++;
            end
            tick();
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", errs);
        end
        mem_cmd_rdy_i = 1'b1;
        tick();
        total++;
        if ({mem_cmd_vld_o, st_req_rdy_o} !== 2'b00) begin
            bad++;
            $display("FAIL backpressure_data: got vld/st_rdy=%b expected 00", {mem_cmd_vld_o, st_req_rdy_o});
        end
        mem_beat_i = 1'b1;
        tick();
        tick();
        mem_beat_i = 1'b0;
        total++;
        if ({ld_done_o, st_req_rdy_o} !== 2'b11) begin
            bad++;
            $display("FAIL backpressure_next: got ld_done/st_rdy=%b expected 11", {ld_done_o, st_req_rdy_o});
        end
        tick();
        st_req_vld_i = 1'b0;
        total++;
        if ({mem_cmd_vld_o, mem_cmd_we_o, mem_cmd_addr_o} !== {1'b1, 1'b1, 32'h9000}) begin
            bad++;
            $display("FAIL backpressure_store_cmd: got vld=%b we=%b addr=%h expected 1 1 9000",
                     mem_cmd_vld_o, mem_cmd_we_o, mem_cmd_addr_o);
        end
        tick();
        mem_beat_i = 1'b1;
        tick();
        tick();
        tick();
        mem_beat_i = 1'b0;
        total++;
        if (st_done_o !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_store_done: got %b expected 1", st_done_o);
        end
        tick();
    endtask

    task automatic test_len_boundary();
        int n;
        apply_reset();
        mem_cmd_rdy_i = 1'b1;
        ld_addr_i = 32'h40;
        ld_len_i = 8'd0;
        ld_req_vld_i = 1'b1;
        tick();
        ld_req_vld_i = 1'b0;
        tick();
        mem_beat_i = 1'b1;
        tick();
        mem_beat_i = 1'b0;
        total++;
        if (ld_done_o !== 1'b1) begin
            bad++;
            $display("FAIL len0_done: got %b expected 1", ld_done_o);
        end
        tick();
        st_addr_i = 32'h8000;
        st_len_i = 8'd255;
        st_req_vld_i = 1'b1;
        tick();
        st_req_vld_i = 1'b0;
        total++;
        if (mem_cmd_len_o !== 8'd255) begin
            bad++;
            $display("FAIL len255_cmd_len: got %0d expected 255", mem_cmd_len_o);
        end
        tick();
        n = 0;
        mem_beat_i = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            n += int'(st_done_o);
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL len255_early: got %0d done pulses within 255 beats expected 0", n);
        end
        tick();
        mem_beat_i = 1'b0;
        total++;
        if (st_done_o !== 1'b1) begin
            bad++;
            $display("FAIL len255_done: got %b after 256 beats expected 1", st_done_o);
        end
        tick();
        total++;
        if ({st_done_o, err_o} !== 2'b00) begin
            bad++;
            $display("FAIL len255_after: got done/err=%b expected 00", {st_done_o, err_o});
        end
    endtask

    task automatic test_protocol_error();
        apply_reset();
        mem_beat_i = 1'b1;
        tick();
        mem_beat_i = 1'b0;
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_idle_beat: got %b expected 1", err_o);
        end
        ld_addr_i = 32'h3000;
        ld_len_i = 8'd1;
        ld_req_vld_i = 1'b1;
        st_req_vld_i = 1'b1;
        st_addr_i = 32'h3100;
        st_len_i = 8'd0;
        mem_cmd_rdy_i = 1'b1;
        #1;
        total++;
        if ({ld_req_rdy_o, st_req_rdy_o} !== 2'b10) begin
            bad++;
            $display("FAIL err_grant: got ld/st rdy=%b expected 10", {ld_req_rdy_o, st_req_rdy_o});
        end
        tick();
        ld_req_vld_i = 1'b0;
        tick();
        mem_beat_i = 1'b1;
        tick();
        tick();
        mem_beat_i = 1'b0;
        total++;
        if ({ld_done_o, st_req_rdy_o, err_o} !== 3'b111) begin
            bad++;
            $display("FAIL err_sticky: got ld_done/st_rdy/err=%b expected 111", {ld_done_o, st_req_rdy_o, err_o});
        end
        tick();
        st_req_vld_i = 1'b0;
        tick();
        mem_beat_i = 1'b1;
        tick();
        mem_beat_i = 1'b0;
        total++;
        if ({st_done_o, err_o} !== 2'b11) begin
            bad++;
            $display("FAIL err_store_burst: got st_done/err=%b expected 11", {st_done_o, err_o});
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        apply_reset();
        mem_cmd_rdy_i = 1'b1;
        ld_addr_i = 32'h5000;
        ld_len_i = 8'd3;
        ld_req_vld_i = 1'b1;
        tick();
        ld_req_vld_i = 1'b0;
        tick();
        mem_beat_i = 1'b1;
        tick();
        tick();
        mem_beat_i = 1'b0;
        st_addr_i = 32'h7700;
        st_len_i = 8'd0;
        st_req_vld_i = 1'b1;
        #1;
        total++;
        if (st_req_rdy_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_rdy_in_data: got %b expected 0", st_req_rdy_o);
        end
        rstn = 1'b0;
        #1;
        total++;
        if (outs() !== 48'h0) begin
            bad++;
            $display("FAIL midrst_outputs: got %h expected %h", outs(), 48'h0);
        end
        n = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n += int'(ld_done_o) + int'(st_done_o);
        end
        rstn = 1'b1;
        #1;
        total++;
        if ({n[1:0], ld_done_o, st_req_rdy_o} !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_release: got done_pulses=%0d ld_done=%b st_rdy=%b expected 0 0 1", n, ld_done_o, st_req_rdy_o);
        end
        tick();
        st_req_vld_i = 1'b0;
        total++;
        if ({mem_cmd_vld_o, mem_cmd_we_o, mem_cmd_addr_o} !== {1'b1, 1'b1, 32'h7700}) begin
            bad++;
            $display("FAIL midrst_store_cmd: got vld=%b we=%b addr=%h expected 1 1 7700",
                     mem_cmd_vld_o, mem_cmd_we_o, mem_cmd_addr_o);
        end
        tick();
        mem_beat_i = 1'b1;
        tick();
        mem_beat_i = 1'b0;
        total++;
        if ({st_done_o, ld_done_o} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_store_done: got st/ld=%b expected 10", {st_done_o, ld_done_o});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_alternation();
        test_backpressure();
        test_len_boundary();
        test_protocol_error();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
